// File: rtl/mesi_req_master.sv
// mesi_req_master
// Core-side request initiator for the mesi_coherency cache port. Accepts one
// read or write command at a time, issues it to the cache for exactly one
// cycle, waits for the write result (fixed latency W_LAT) or the read data
// (bounded by TIMEOUT), then holds a single response beat until it is taken.
//
// Optional feature macro: MESI_REQ_STATS_EN adds 16-bit saturating outcome
// counters (stat_rd_hit, stat_rd_miss, stat_wr_hit, stat_wr_miss, stat_timeout).
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_write/cmd_addr/cmd_wdata    command payload
//   data_addr/wdata                 cache address and write data
//   awvalid/wvalid/arvalid          cache issue strobes
//   rvalid/rdata/r_hit/r_resp       cache read return
//   w_hit/w_resp                    cache write result
//   rsp_valid/rsp_ready             response handshake
//   rsp_write/rsp_rdata/rsp_hit/
//   rsp_code/rsp_timeout            response payload
//   stat_*                          outcome counters (MESI_REQ_STATS_EN only)
//   busy                            high whenever not idle
module mesi_req_master #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int W_LAT   = 1,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] wdata,
  output logic              awvalid,
  output logic              wvalid,
  output logic              arvalid,
  input  logic              rvalid,
  input  logic [DATA_W-1:0] rdata,
  input  logic              r_hit,
  input  logic              w_hit,
  input  logic [1:0]        r_resp,
  input  logic [1:0]        w_resp,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_hit,
  output logic [1:0]        rsp_code,
  output logic              rsp_timeout,
`ifdef MESI_REQ_STATS_EN
  output logic [15:0]       stat_rd_hit,
  output logic [15:0]       stat_rd_miss,
  output logic [15:0]       stat_wr_hit,
  output logic [15:0]       stat_wr_miss,
  output logic [15:0]       stat_timeout,
`endif
  output logic              busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WR_WAIT = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic [3:0] W_LAT_C   = 4'(W_LAT);
  localparam logic [9:0] TIMEOUT_C = 10'(TIMEOUT);

  logic [2:0]        state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [9:0]        rcnt_q, rcnt_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_hit_q, rsp_hit_d;
  logic [1:0]        rsp_code_q, rsp_code_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  always_comb begin
    state_d       = state_q;
    wr_d          = wr_q;
    data_addr_d   = data_addr_q;
    wdata_d       = wdata_q;
    wcnt_d        = wcnt_q;
    rcnt_d        = rcnt_q;
    rsp_write_d   = rsp_write_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_hit_d     = rsp_hit_q;
    rsp_code_d    = rsp_code_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d     = S_ISSUE;
          wr_d        = cmd_write;
          data_addr_d = cmd_addr;
          wdata_d     = cmd_wdata;
        end
      end
      S_ISSUE: begin
        if (wr_q) begin
          state_d = S_WR_WAIT;
          wcnt_d  = 4'd1;
        end else begin
          state_d = S_RD_WAIT;
          rcnt_d  = 10'd1;
        end
      end
      S_WR_WAIT: begin
        wcnt_d = wcnt_q + 4'd1;
        if (wcnt_q == W_LAT_C) begin
          state_d       = S_RESP;
          rsp_write_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_hit_d     = w_hit;
          rsp_code_d    = w_resp;
          rsp_timeout_d = 1'b0;
        end
      end
      S_RD_WAIT: begin
        rcnt_d = rcnt_q + 10'd1;
        // A real return in the final counted cycle takes priority over the timeout.
        if (rvalid) begin
          state_d       = S_RESP;
          rsp_write_d   = 1'b0;
          rsp_rdata_d   = rdata;
          rsp_hit_d     = r_hit;
          rsp_code_d    = r_resp;
          rsp_timeout_d = 1'b0;
        end else if (rcnt_q == TIMEOUT_C) begin
          state_d       = S_RESP;
          rsp_write_d   = 1'b0;
          rsp_rdata_d   = '0;
          rsp_hit_d     = 1'b0;
          rsp_code_d    = 2'b11;
          rsp_timeout_d = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d       = S_IDLE;
          // Timeout flag only accompanies the beat it belongs to.
          rsp_timeout_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_q          <= 1'b0;
      data_addr_q   <= '0;
      wdata_q       <= '0;
      wcnt_q        <= '0;
      rcnt_q        <= '0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_hit_q     <= 1'b0;
      rsp_code_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      data_addr_q   <= data_addr_d;
      wdata_q       <= wdata_d;
      wcnt_q        <= wcnt_d;
      rcnt_q        <= rcnt_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_hit_q     <= rsp_hit_d;
      rsp_code_q    <= rsp_code_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign awvalid     = (state_q == S_ISSUE) && wr_q;
  assign wvalid      = (state_q == S_ISSUE) && wr_q;
  assign arvalid     = (state_q == S_ISSUE) && !wr_q;
  assign data_addr   = data_addr_q;
  assign wdata       = wdata_q;
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_write   = rsp_write_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_hit     = rsp_hit_q;
  assign rsp_code    = rsp_code_q;
  assign rsp_timeout = rsp_timeout_q;

`ifdef MESI_REQ_STATS_EN
  logic [15:0] stat_rd_hit_q, stat_rd_hit_d;
  logic [15:0] stat_rd_miss_q, stat_rd_miss_d;
  logic [15:0] stat_wr_hit_q, stat_wr_hit_d;
  logic [15:0] stat_wr_miss_q, stat_wr_miss_d;
  logic [15:0] stat_timeout_q, stat_timeout_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Outcomes are classified from the values about to be registered for the beat.
  always_comb begin
    stat_rd_hit_d  = stat_rd_hit_q;
    stat_rd_miss_d = stat_rd_miss_q;
    stat_wr_hit_d  = stat_wr_hit_q;
    stat_wr_miss_d = stat_wr_miss_q;
    stat_timeout_d = stat_timeout_q;
    if (state_q == S_RD_WAIT && state_d == S_RESP) begin
      if (rsp_timeout_d)  stat_timeout_d = sat_inc(stat_timeout_q);
      else if (rsp_hit_d) stat_rd_hit_d  = sat_inc(stat_rd_hit_q);
      else                stat_rd_miss_d = sat_inc(stat_rd_miss_q);
    end
    if (state_q == S_WR_WAIT && state_d == S_RESP) begin
      if (rsp_hit_d) stat_wr_hit_d  = sat_inc(stat_wr_hit_q);
      else           stat_wr_miss_d = sat_inc(stat_wr_miss_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd_hit_q  <= '0;
      stat_rd_miss_q <= '0;
      stat_wr_hit_q  <= '0;
      stat_wr_miss_q <= '0;
      stat_timeout_q <= '0;
    end else begin
      stat_rd_hit_q  <= stat_rd_hit_d;
      stat_rd_miss_q <= stat_rd_miss_d;
      stat_wr_hit_q  <= stat_wr_hit_d;
      stat_wr_miss_q <= stat_wr_miss_d;
      stat_timeout_q <= stat_timeout_d;
    end
  end

  assign stat_rd_hit  = stat_rd_hit_q;
  assign stat_rd_miss = stat_rd_miss_q;
  assign stat_wr_hit  = stat_wr_hit_q;
  assign stat_wr_miss = stat_wr_miss_q;
  assign stat_timeout = stat_timeout_q;
`endif

endmodule

// File: tb/tb_mesi_req_master.sv
// tb_mesi_req_master
// Self-checking bench for mesi_req_master (W_LAT=1, TIMEOUT=8). A table of
// command/cache-behaviour records, each with expected response and latency
// computed from the protocol rules, is replayed cycle by cycle; hand-written
// sequences cover backpressure, mid-operation reset and stray rvalid.
// Statistics outputs are checked when MESI_REQ_STATS_EN is defined.
module tb_mesi_req_master;

  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 32;
  localparam int W_LAT   = 1;
  localparam int TIMEOUT = 8;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] wdata;
  logic              awvalid;
  logic              wvalid;
  logic              arvalid;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              r_hit;
  logic              w_hit;
  logic [1:0]        r_resp;
  logic [1:0]        w_resp;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_hit;
  logic [1:0]        rsp_code;
  logic              rsp_timeout;
  logic              busy;
`ifdef MESI_REQ_STATS_EN
  logic [15:0] stat_rd_hit, stat_rd_miss, stat_wr_hit, stat_wr_miss, stat_timeout;
`endif

  mesi_req_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .W_LAT(W_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .data_addr(data_addr), .wdata(wdata),
    .awvalid(awvalid), .wvalid(wvalid), .arvalid(arvalid),
    .rvalid(rvalid), .rdata(rdata), .r_hit(r_hit), .w_hit(w_hit),
    .r_resp(r_resp), .w_resp(w_resp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_hit(rsp_hit), .rsp_code(rsp_code),
    .rsp_timeout(rsp_timeout),
`ifdef MESI_REQ_STATS_EN
    .stat_rd_hit(stat_rd_hit), .stat_rd_miss(stat_rd_miss),
    .stat_wr_hit(stat_wr_hit), .stat_wr_miss(stat_wr_miss),
    .stat_timeout(stat_timeout),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One transaction: command, cache behaviour, and expected response.
  // dly: rvalid arrives in cycle 1+dly after accept (strobe cycle is 1);
  // dly 0 puts rvalid only in the strobe cycle, large dly means never.
  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdat;
    int                dly;
    logic [DATA_W-1:0] rdat;
    logic              hit;
    logic [1:0]        code;
    logic              stray;
    int                bp;
    int                exp_lat;
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_hit;
    logic [1:0]        exp_code;
    logic              exp_to;
  } vec_t;

  vec_t vecs[$];

  int compared   = 0;
  int mismatched = 0;
  int m_rd_hit = 0, m_rd_miss = 0, m_wr_hit = 0, m_wr_miss = 0, m_timeout = 0;

  // Reference model: response contents and the cycle (counted from the
  // accept edge) in which rsp_valid first appears.
  function automatic vec_t mkVec(input logic wr, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdat, input int dly,
                                 input logic [DATA_W-1:0] rdat, input logic hit,
                                 input logic [1:0] code, input logic stray,
                                 input int bp);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdat = wdat; v.dly = dly; v.rdat = rdat;
    v.hit = hit; v.code = code; v.stray = stray; v.bp = bp;
    if (wr) begin
      v.exp_lat = 2 + W_LAT; v.exp_rdata = '0; v.exp_hit = hit;
      v.exp_code = code; v.exp_to = 1'b0;
    end else if (dly >= 1 && dly <= TIMEOUT) begin
      v.exp_lat = 2 + dly; v.exp_rdata = rdat; v.exp_hit = hit;
      v.exp_code = code; v.exp_to = 1'b0;
    end else begin
      v.exp_lat = 2 + TIMEOUT; v.exp_rdata = '0; v.exp_hit = 1'b0;
      v.exp_code = 2'b11; v.exp_to = 1'b1;
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic countOutcome(input vec_t v);
    if (v.wr) begin
      if (v.exp_hit) m_wr_hit++; else m_wr_miss++;
    end else if (v.exp_to) m_timeout++;
    else if (v.exp_hit) m_rd_hit++;
    else m_rd_miss++;
  endtask

  // Replays one record; a decoy command sits on the bus while busy and the
  // cache drives deliberately wrong payload outside the sampling cycle.
  task automatic applyStimulus(input vec_t v);
    int total;
    @(negedge clk);
    checkOutput("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdat;
    rsp_ready = 1'b0;
    @(posedge clk);
    total = v.exp_lat + v.bp;
    for (int cyc = 1; cyc <= total; cyc++) begin
      @(negedge clk);
      cmd_valid = (cyc != total);
      cmd_write = ~v.wr; cmd_addr = ~v.addr; cmd_wdata = ~v.wdat;
      rvalid = !v.wr && ((cyc == 1 + v.dly) || (cyc == 1 && v.stray));
      rdata  = (cyc == 1 + v.dly) ? v.rdat : ~v.rdat;
      r_hit  = (cyc == 1 + v.dly) ? v.hit : ~v.hit;
      r_resp = (cyc == 1 + v.dly) ? v.code : ~v.code;
      w_hit  = (cyc == 1 + W_LAT) ? v.hit : ~v.hit;
      w_resp = (cyc == 1 + W_LAT) ? v.code : ~v.code;
      rsp_ready = (cyc == total);
      if (cyc == 1) begin
        checkOutput("issue_awvalid", awvalid, v.wr);
        checkOutput("issue_wvalid", wvalid, v.wr);
        checkOutput("issue_arvalid", arvalid, !v.wr);
        checkOutput("issue_data_addr", data_addr, v.addr);
        checkOutput("issue_wdata", wdata, v.wdat);
        checkOutput("issue_busy", busy, 1);
      end else begin
        checkOutput("strobes_low", {awvalid, wvalid, arvalid}, 0);
      end
      if (cyc < v.exp_lat) begin
        checkOutput("rsp_valid_early", rsp_valid, 0);
      end else begin
        checkOutput("rsp_valid", rsp_valid, 1);
        checkOutput("rsp_write", rsp_write, v.wr);
        checkOutput("rsp_rdata", rsp_rdata, v.exp_rdata);
        checkOutput("rsp_hit", rsp_hit, v.exp_hit);
        checkOutput("rsp_code", rsp_code, v.exp_code);
        checkOutput("rsp_timeout", rsp_timeout, v.exp_to);
        checkOutput("rsp_data_addr", data_addr, v.addr);
        checkOutput("rsp_cmd_ready", cmd_ready, 0);
      end
    end
    @(negedge clk);
    rvalid = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    checkOutput("done_rsp_valid", rsp_valid, 0);
    checkOutput("done_cmd_ready", cmd_ready, 1);
    checkOutput("done_busy", busy, 0);
    checkOutput("done_rsp_timeout", rsp_timeout, 0);
    countOutcome(v);
  endtask

`ifdef MESI_REQ_STATS_EN
  task automatic checkStats(input int rh, input int rm, input int wh,
                            input int wm, input int to);
    checkOutput("stat_rd_hit", stat_rd_hit, 64'(rh));
    checkOutput("stat_rd_miss", stat_rd_miss, 64'(rm));
    checkOutput("stat_wr_hit", stat_wr_hit, 64'(wh));
    checkOutput("stat_wr_miss", stat_wr_miss, 64'(wm));
    checkOutput("stat_timeout", stat_timeout, 64'(to));
  endtask
`endif

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rvalid = 1'b0; rdata = '0; r_hit = 1'b0; w_hit = 1'b0; r_resp = 2'b00;
    w_resp = 2'b00; rsp_ready = 1'b0;

    // Directed records followed by randomized ones.
    vecs.push_back(mkVec(1'b1, 20'h00010, 32'hDEADBEEF, 0, 32'h0, 1'b1, 2'b00, 1'b0, 0));
    vecs.push_back(mkVec(1'b0, 20'h00010, 32'h0, 3, 32'hDEADBEEF, 1'b0, 2'b00, 1'b0, 0));
    vecs.push_back(mkVec(1'b0, 20'h00200, 32'h0, 1000, 32'h12345678, 1'b1, 2'b00, 1'b0, 1));
    vecs.push_back(mkVec(1'b1, 20'hABCDE, 32'h0BADF00D, 0, 32'h0, 1'b0, 2'b10, 1'b0, 2));
    vecs.push_back(mkVec(1'b0, 20'h00300, 32'h0, TIMEOUT, 32'hCAFEF00D, 1'b1, 2'b01, 1'b0, 0));
    vecs.push_back(mkVec(1'b0, 20'h00400, 32'h0, 1, 32'h5A5A5A5A, 1'b1, 2'b00, 1'b1, 0));
    vecs.push_back(mkVec(1'b0, 20'h00500, 32'h0, TIMEOUT + 1, 32'h77777777, 1'b1, 2'b00, 1'b0, 0));
    vecs.push_back(mkVec(1'b0, 20'h00600, 32'h0, 0, 32'h99999999, 1'b1, 2'b00, 1'b0, 0));
    for (int i = 0; i < 40; i++) begin
      vecs.push_back(mkVec(1'($urandom_range(0, 1)), 20'($urandom), $urandom,
                           int'($urandom_range(0, TIMEOUT + 3)), $urandom,
                           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                           1'($urandom_range(0, 1)), int'($urandom_range(0, 3))));
    end

    // Reset values while reset is held.
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_strobes", {awvalid, wvalid, arvalid}, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_timeout", rsp_timeout, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_data_addr", data_addr, 0);
    checkOutput("rst_wdata", wdata, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 0);
    checkOutput("rst_rsp_code", rsp_code, 0);
    checkOutput("rst_rsp_hit", rsp_hit, 0);
    rst = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Backpressure: next command waits on the bus while the beat is held.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h11111; cmd_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    cmd_write = 1'b1; cmd_addr = 20'h22222; cmd_wdata = 32'hFEEDFACE;
    @(negedge clk);
    rvalid = 1'b1; rdata = 32'h31415926; r_hit = 1'b1; r_resp = 2'b00;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rvalid = 1'b0; rdata = '0; r_hit = 1'b0; r_resp = 2'b11;
      checkOutput("bp_rsp_valid", rsp_valid, 1);
      checkOutput("bp_rsp_rdata", rsp_rdata, 32'h31415926);
      checkOutput("bp_rsp_hit", rsp_hit, 1);
      checkOutput("bp_rsp_code", rsp_code, 2'b00);
      checkOutput("bp_cmd_ready", cmd_ready, 0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    checkOutput("bp_rsp_still_valid", rsp_valid, 1);
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("bp_ready_after", cmd_ready, 1);
    checkOutput("bp_rsp_dropped", rsp_valid, 0);
    checkOutput("bp_no_same_cycle_issue", awvalid, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("bp_next_awvalid", awvalid, 1);
    checkOutput("bp_next_addr", data_addr, 20'h22222);
    checkOutput("bp_next_wdata", wdata, 32'hFEEDFACE);
    @(negedge clk);
    w_hit = 1'b0; w_resp = 2'b10;
    @(negedge clk);
    w_hit = 1'b1; w_resp = 2'b00;
    checkOutput("bp_wr_rsp_valid", rsp_valid, 1);
    checkOutput("bp_wr_rsp_write", rsp_write, 1);
    checkOutput("bp_wr_rsp_hit", rsp_hit, 0);
    checkOutput("bp_wr_rsp_code", rsp_code, 2'b10);
    checkOutput("bp_wr_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("bp_wr_done", busy, 0);
    m_rd_hit++; m_wr_miss++;

`ifdef MESI_REQ_STATS_EN
    checkStats(m_rd_hit, m_rd_miss, m_wr_hit, m_wr_miss, m_timeout);
`endif

    // Reset during RD_WAIT drops the command; rvalid afterwards is ignored.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h33333;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_strobes", {awvalid, wvalid, arvalid}, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_rsp_valid", rsp_valid, 0);
    checkOutput("midrst_data_addr", data_addr, 0);
    m_rd_hit = 0; m_rd_miss = 0; m_wr_hit = 0; m_wr_miss = 0; m_timeout = 0;
    @(negedge clk);
    rst = 1'b0;
    rvalid = 1'b1; rdata = 32'hBAADBAAD; r_hit = 1'b1; r_resp = 2'b01;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("stray_rsp_valid", rsp_valid, 0);
      checkOutput("stray_busy", busy, 0);
      checkOutput("stray_cmd_ready", cmd_ready, 1);
    end
    rvalid = 1'b0;

    // Outcome mix: 3 read hits, 2 write misses, 1 timeout.
    applyStimulus(mkVec(1'b0, 20'h00A00, 32'h0, 2, 32'h01010101, 1'b1, 2'b00, 1'b0, 0));
    applyStimulus(mkVec(1'b0, 20'h00A04, 32'h0, 1, 32'h02020202, 1'b1, 2'b01, 1'b0, 1));
    applyStimulus(mkVec(1'b1, 20'h00A08, 32'h03030303, 0, 32'h0, 1'b0, 2'b00, 1'b0, 0));
    applyStimulus(mkVec(1'b0, 20'h00A0C, 32'h0, 5, 32'h04040404, 1'b1, 2'b00, 1'b0, 0));
    applyStimulus(mkVec(1'b0, 20'h00A10, 32'h0, 1000, 32'h0, 1'b0, 2'b00, 1'b0, 0));
    applyStimulus(mkVec(1'b1, 20'h00A14, 32'h05050505, 0, 32'h0, 1'b0, 2'b10, 1'b0, 0));
`ifdef MESI_REQ_STATS_EN
    checkStats(3, 0, 0, 2, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
